// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end and ALU core: key indices,
// loader state encoding and the opcode type.
package alu_pkg;

  localparam int KEY_LOAD_A  = 0;
  localparam int KEY_LOAD_B  = 1;
  localparam int KEY_LOAD_OP = 2;
  localparam int KEY_EXEC    = 3;

  localparam int ALU_OPCODE_W = 4;

  typedef logic [ALU_OPCODE_W-1:0] opcode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } loader_state_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, mismatch counter that
// accepts a level change after DEBOUNCE_CYCLES consecutive differing
// samples, and a registered one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the raw key into the clk domain; idle level is released (1).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Count mismatching samples, flip the debounced level on the last one,
  // and pulse only when that flip is released -> pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        // a mismatch with level high means the key just went low
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Operand loader in front of the ALU core: debounces four keys, captures
// A, B and opcode from the switches, and issues one valid/ready
// transaction per execute press.
// Optional build macro ALU_LOADER_ACC_EN: load A with sw[17]=1 takes
// result_in instead of the switches (accumulator chaining).
//
// state | meaning
// IDLE  | accepting loads; execute issues if all operands are loaded
// ISSUE | op_valid held, operands frozen, waiting for op_ready
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OPCODE_W        = ALU_OPCODE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [17:0]         sw,
  input  logic [3:0]          key_n,
  input  logic [WIDTH-1:0]    result_in,
  output logic [WIDTH-1:0]    a,
  output logic [WIDTH-1:0]    b,
  output logic [OPCODE_W-1:0] opcode,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [2:0]          loaded,
  output logic                busy,
  output logic                err
);

  logic [3:0]       ev;
  logic [2:0]       loaded_next;
  logic [WIDTH-1:0] a_src;
  loader_state_t    state;
  logic             unused_inputs;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n[k]),
      .press(ev[k])
    );
  end

  // Flags as they will be after this cycle's loads, so a simultaneous
  // execute sees operands that are being loaded right now.
  always_comb begin
    loaded_next = loaded | {ev[KEY_LOAD_OP], ev[KEY_LOAD_B], ev[KEY_LOAD_A]};
  end

  // Source for operand A.
`ifdef ALU_LOADER_ACC_EN
  always_comb begin
    a_src = sw[17] ? result_in : sw[WIDTH-1:0];
  end
`else
  always_comb begin
    a_src = sw[WIDTH-1:0];
  end
`endif

  // Switch bits above the operand field and the feedback path are not
  // needed in every build.
  assign unused_inputs = ^{sw, result_in};

  // Load/issue state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      opcode   <= '0;
      op_valid <= 1'b0;
      loaded   <= 3'b000;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ev[KEY_LOAD_A])  a      <= a_src;
          if (ev[KEY_LOAD_B])  b      <= sw[WIDTH-1:0];
          if (ev[KEY_LOAD_OP]) opcode <= sw[OPCODE_W-1:0];
          loaded <= loaded_next;
          if (ev[KEY_EXEC]) begin
            if (&loaded_next) begin
              state    <= ISSUE;
              op_valid <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // key events are dropped here; operands stay frozen
          if (op_valid && op_ready) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

  localparam int WIDTH = 16;
  localparam int DB    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [17:0]       sw;
  logic [3:0]        key_n;
  logic [WIDTH-1:0]  result_in;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [3:0]        opcode;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        loaded;
  logic              busy;
  logic              err;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  int xfer_cnt = 0;

  alu_operand_loader #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .OPCODE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .key_n(key_n), .result_in(result_in),
    .a(a), .b(b), .opcode(opcode), .op_valid(op_valid), .op_ready(op_ready),
    .loaded(loaded), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle counters observed just before each active edge.
  always @(posedge clk) begin
    if (err) err_cnt++;
    if (op_valid) valid_cnt++;
    if (op_valid && op_ready) xfer_cnt++;
  end

  typedef struct {
    int          key;
    logic [17:0] swv;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [3:0]  eop;
    logic [2:0]  eld;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_n = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int k, input logic [17:0] swv);
    @(negedge clk);
    sw = swv;
    key_n[k] = 1'b0;
    repeat (8) @(negedge clk);
    key_n[k] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{0, 18'h00003, 16'h0003, 16'h0000, 4'h0, 3'b001};
    vecs[1] = '{1, 18'h00005, 16'h0003, 16'h0005, 4'h0, 3'b011};
    vecs[2] = '{2, 18'h00002, 16'h0003, 16'h0005, 4'h2, 3'b111};
    vecs[3] = '{0, 18'h0FFFF, 16'hFFFF, 16'h0005, 4'h2, 3'b111};
    vecs[4] = '{2, 18'h0ABCD, 16'hFFFF, 16'h0005, 4'hD, 3'b111};
    vecs[5] = '{0, 18'h00003, 16'h0003, 16'h0005, 4'hD, 3'b111};
    vecs[6] = '{2, 18'h00002, 16'h0003, 16'h0005, 4'h2, 3'b111};

    rst = 1'b1;
    sw = '0;
    key_n = 4'hF;
    result_in = '0;
    op_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset a", a, 0);
    check("reset b", b, 0);
    check("reset opcode", opcode, 0);
    check("reset op_valid", op_valid, 0);
    check("reset loaded", loaded, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    rst = 1'b0;

    // Latency of load A: update lands DB+2 edges after the first low sample.
    @(negedge clk);
    sw = 18'h01234;
    key_n[0] = 1'b0;
    repeat (DB + 2) @(negedge clk);
    check("latency a before", a, 16'h0000);
    @(negedge clk);
    check("latency a after", a, 16'h1234);
    sw = 18'h05555;
    repeat (14) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("held key single event", a, 16'h1234);
    check("held key loaded", loaded, 3'b001);

    // Short glitch on load B must be rejected.
    @(negedge clk);
    sw = 18'h0FFFF;
    key_n[1] = 1'b0;
    repeat (2) @(negedge clk);
    key_n[1] = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch b", b, 16'h0000);
    check("glitch loaded", loaded, 3'b001);

    // Table of single-key loads.
    err_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      press(vecs[i].key, vecs[i].swv);
      check($sformatf("vec%0d a", i), a, vecs[i].ea);
      check($sformatf("vec%0d b", i), b, vecs[i].eb);
      check($sformatf("vec%0d opcode", i), opcode, vecs[i].eop);
      check($sformatf("vec%0d loaded", i), loaded, vecs[i].eld);
      check($sformatf("vec%0d op_valid", i), op_valid, 0);
    end
    check("loads no err", err_cnt, 0);

    // Execute with downstream stalled; operands freeze in ISSUE.
    xfer_cnt = 0;
    press(3, 18'h0);
    check("issue op_valid", op_valid, 1);
    check("issue busy", busy, 1);
    press(0, 18'h09999);
    check("issue a frozen", a, 16'h0003);
    check("issue still valid", op_valid, 1);
    check("issue no err", err_cnt, 0);
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    check("xfer op_valid drop", op_valid, 0);
    check("xfer busy drop", busy, 0);
    check("xfer count", xfer_cnt, 1);
    check("xfer loaded sticky", loaded, 3'b111);
    check("xfer operands", {a, b, 12'h0, opcode}, {16'h0003, 16'h0005, 12'h0, 4'h2} & 32'hFFFFFFFF);

    // Reissue with op_ready already high: one-cycle valid.
    valid_cnt = 0;
    xfer_cnt = 0;
    press(3, 18'h0);
    check("reissue valid cycles", valid_cnt, 1);
    check("reissue transfers", xfer_cnt, 1);
    op_ready = 1'b0;

    // Execute with an operand missing.
    do_reset();
    press(0, 18'h00007);
    err_cnt = 0;
    valid_cnt = 0;
    press(3, 18'h0);
    check("err pulse cycles", err_cnt, 1);
    check("err no valid", valid_cnt, 0);
    check("err state idle", busy, 0);

    // Accumulator select on load A.
    do_reset();
    result_in = 16'h00AB;
    press(0, 18'h21234);
`ifdef ALU_LOADER_ACC_EN
    check("acc load a", a, 16'h00AB);
`else
    check("acc load a", a, 16'h1234);
`endif
    check("acc loaded", loaded, 3'b001);

    // All keys at once: loads apply and execute issues with new values.
    do_reset();
    @(negedge clk);
    sw = 18'h00042;
    key_n = 4'h0;
    repeat (8) @(negedge clk);
    key_n = 4'hF;
    repeat (8) @(negedge clk);
    check("simul a", a, 16'h0042);
    check("simul b", b, 16'h0042);
    check("simul opcode", opcode, 4'h2);
    check("simul loaded", loaded, 3'b111);
    check("simul op_valid", op_valid, 1);

    // Reset while in ISSUE.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst issue op_valid", op_valid, 0);
    check("rst issue loaded", loaded, 0);
    check("rst issue a", a, 0);
    check("rst issue b", b, 0);
    check("rst issue opcode", opcode, 0);
    check("rst issue busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front-end stage directly upstream of the ALU core on the DE2 board.
- Turns the raw slide switches and active-low push-buttons into clean, registered operands A, B and an opcode.
- Issues one valid/ready transaction per "execute" press, so the ALU sees stable, deliberate inputs instead of live switch levels.
- Contains per-key synchronisation, debounce and edge detection, a load/issue state machine, and status outputs for the green LEDs.

Parameters:
- WIDTH, 16: operand width for A and B.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a key level change (10 ms at 50 MHz). Must be >= 2.
- OPCODE_W, 4: opcode width, taken from sw[OPCODE_W-1:0].

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- sw  in  18  slide switches. sw[WIDTH-1:0] is operand/opcode data; sw[17] is the accumulator select (used only with the optional feature).
- key_n  in  4  raw push-buttons, active-low. [0]=load A, [1]=load B, [2]=load opcode, [3]=execute.
- result_in  in  WIDTH  ALU result fed back. Ignored unless the optional feature is compiled in.
- a  out  WIDTH  registered operand A.
- b  out  WIDTH  registered operand B.
- opcode  out  OPCODE_W  registered opcode.
- op_valid  out  1  transaction valid.
- op_ready  in  1  downstream ALU accepts the transaction.
- loaded  out  3  sticky flags {opcode, b, a} loaded.
- busy  out  1  high in ISSUE state.
- err  out  1  one-cycle pulse: execute pressed with an operand missing.

Behaviour:
- Reset (rst=1 at a clk edge):
  - a=0, b=0, opcode=0, op_valid=0, loaded=0, busy=0, err=0.
  - Synchroniser flops = 1; debounced levels = 1 (released); debounce counters = 0.
  - State = IDLE. A reset asserted in ISSUE drops op_valid on the next edge, with no transfer.
- Per key:
  - 2-flop synchroniser.
  - Debounce counter: increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced level flips and the counter clears.
  - Press event: registered one-cycle pulse on the debounced 1->0 transition. Releases generate no event.
- Latency: key_n low sampled at edge E -> press event high in the cycle after edge E+1+DEBOUNCE_CYCLES -> register/flag update at the next edge (E+2+DEBOUNCE_CYCLES). A key held low produces exactly one event; a bounce shorter than DEBOUNCE_CYCLES produces none.
- State IDLE:
  - Load A event: a<=sw[WIDTH-1:0], loaded[0]<=1.
  - Load B event: b<=sw[WIDTH-1:0], loaded[1]<=1.
  - Load opcode event: opcode<=sw[OPCODE_W-1:0], loaded[2]<=1.
  - Execute event:
    - If all flags, counting loads in the same cycle, are set: go to ISSUE with op_valid<=1.
    - Otherwise: err<=1 for one cycle and stay in IDLE.
- Simultaneous events in IDLE: every load applies, and an execute in the same cycle issues with the newly loaded values.
- State ISSUE:
  - busy=1; op_valid=1; a, b and opcode are frozen.
  - Load and execute events are discarded (no err).
  - Transfer at any edge with op_valid & op_ready, then go to IDLE with op_valid<=0 at that edge.
  - If op_ready is already high on the first ISSUE cycle, op_valid lasts exactly one cycle.
- Loaded flags stay set after a transfer; repeated execute presses reissue the same operands. Flags clear only on reset.
- No wrap-around or arithmetic: operands are captured verbatim, with no sign handling.

Optional Feature:
- Macro: ALU_LOADER_ACC_EN.
- Defined: on a load A event with sw[17]=1, a<=result_in instead of switches (accumulator chaining); loaded[0]<=1 as normal.
- Undefined: sw[17] and result_in are ignored, and a always comes from the switches.

Decomposition:
- Shared package alu_pkg:
  - Key index constants KEY_LOAD_A=0, KEY_LOAD_B=1, KEY_LOAD_OP=2, KEY_EXEC=3.
  - State enum {IDLE, ISSUE}.
  - Opcode typedef of OPCODE_W bits, shared with the ALU core.
- Sub-module key_debounce: synchroniser, counter and press-pulse for one key. Instantiated 4x with parameter DEBOUNCE_CYCLES.

Test Plan (bench sets DEBOUNCE_CYCLES=4):
- Reset, then sw=0x1234 and hold key_n[0] low for 20 cycles -> a=0x1234 exactly 6 edges after the first low sample, loaded=3'b001, a single event only.
- Glitch key_n[1] low for 2 cycles with sw=0xFFFF -> b stays 0 and loaded[1] stays 0.
- Load A=0x0003, B=0x0005, opcode=0x2, op_ready=0, press execute -> op_valid=1 and busy=1 held; press key_n[0] with sw=0x9999 -> a stays 0x0003; raise op_ready -> one transfer, op_valid=0 next cycle.
- From reset, load only A then press execute -> err pulses for 1 cycle, op_valid stays 0.
- With ALU_LOADER_ACC_EN defined: result_in=0x00AB, sw[17]=1, press load A -> a=0x00AB. With it undefined -> a=sw[15:0].
- Assert rst during ISSUE -> next edge: op_valid=0, loaded=0, a=b=opcode=0.
